// File: rtl/dual_core_data_arbiter.sv
// Shares one data-memory port between two cores: round-robin address phase with
// hold-until-grant, and an in-order ID FIFO that routes each response back to its issuer.
module dual_core_data_arbiter #(
    parameter int ADR_W   = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              m0_req,
    input  logic [ADR_W-1:0]  m0_adr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADR_W-1:0]  m1_adr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic [ADR_W-1:0]  s_adr,
    output logic              s_we,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_gnt,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              err_rvalid
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    logic               lock_vld_q, lock_vld_d;
    logic               lock_id_q, lock_id_d;
    logic               last_id_q, last_id_d;
    logic [MAX_OUT-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;

    logic sel_s;
    logic can_issue_s;
    logic s_req_s;
    logic grant_s;
    logic pop_s;
    logic head_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Address-phase selection, grant qualification and response pop decision.
    always_comb begin
        sel_s = 1'b0;
        if (lock_vld_q) begin
            sel_s = lock_id_q;
        end else if (m0_req && m1_req) begin
            sel_s = ~last_id_q;
        end else if (m1_req) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        can_issue_s = (count_q < MAX_CNT);
        // Gating with res keeps every output quiet while reset is asserted.
        s_req_s = res & can_issue_s & (lock_vld_q | m0_req | m1_req);
        grant_s = s_req_s & s_gnt;
        pop_s   = res & s_rvalid & (count_q != {CNT_W{1'b0}});
        head_s  = fifo_q[rd_ptr_q];
    end

    assign s_req      = s_req_s;
    assign s_adr      = s_req_s ? (sel_s ? m1_adr : m0_adr) : {ADR_W{1'b0}};
    assign s_we       = s_req_s & (sel_s ? m1_we : m0_we);
    assign s_wdata    = s_req_s ? (sel_s ? m1_wdata : m0_wdata) : {DATA_W{1'b0}};
    assign m0_gnt     = grant_s & ~sel_s;
    assign m1_gnt     = grant_s & sel_s;
    assign m0_rvalid  = pop_s & ~head_s;
    assign m1_rvalid  = pop_s & head_s;
    assign m0_rdata   = res ? s_rdata : {DATA_W{1'b0}};
    assign m1_rdata   = res ? s_rdata : {DATA_W{1'b0}};
    assign err_rvalid = err_q;

    // Next-state for the hold lock, round-robin pointer, ID FIFO and error flag.
    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        last_id_d  = last_id_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (grant_s) begin
            lock_vld_d       = 1'b0;
            last_id_d        = sel_s;
            fifo_d[wr_ptr_q] = sel_s;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else if (s_req_s) begin
            lock_vld_d = 1'b1;
            lock_id_d  = sel_s;
        end else begin
            lock_vld_d = lock_vld_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({grant_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        err_d = err_q | (s_rvalid & (count_q == {CNT_W{1'b0}}));
    end

    // State registers; reset discards all outstanding transactions.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
            last_id_q  <= 1'b1;
            fifo_q     <= {MAX_OUT{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
            last_id_q  <= last_id_d;
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

endmodule
